// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : fetch FSM states (WAIT after reset release, then RUN)
//   INSTR_BYTES   : PC increment per fetched instruction
//   CNT_W         : width of the FIFO occupancy count (covers DEPTH up to 4)
//   fetch_entry_t : {pc, instr} pair carried through the fetch FIFO
package fetch_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned CNT_W       = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO of fetch entries between fetch and decode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wr_data  : write wr_data at the tail
//   pop            : retire the head entry
//   flush          : empty the FIFO; overrides push and pop
//   rd_data        : head entry (held stable until popped)
//   full, empty    : occupancy flags
//   count          : number of valid entries
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, push and pop together target the same slot; the
            // old head is being retired in this cycle, so overwriting is safe.
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage. Owns the PC, reads instruction_memory
// combinationally at pc, and queues {pc, instr} pairs for decode.
//   clk, reset          : clock, asynchronous active-low reset
//   pc                  : registered fetch address to instruction memory
//   instruction_code    : word returned by memory at pc
//   redirect_valid/_pc  : branch/jump redirect from execute (flushes queue)
//   if_valid/if_ready   : decode handshake; if_instr/if_pc are the head entry
//   misalign_err        : one-cycle pulse after a redirect with pc[1:0] != 0
// Optional feature macro FETCH_STATS_EN adds fetch_count (pushes) and
// stall_count (RUN cycles with the queue full and no pop).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count_unused;  // occupancy, kept for debug visibility
    fetch_entry_t     wr_entry, head;

    assign wr_entry = '{pc: pc_q, instr: instruction_code};

    always_comb begin
        pop     = if_valid && if_ready;
        // Redirect wins: nothing is pushed in a redirect cycle.
        push    = (state_q == RUN) && !redirect_valid && (!fifo_full || pop);
        // WAIT only lasts one cycle, whatever else happens.
        state_d = RUN;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WAIT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_unused)
    );

    assign pc           = pc_q;
    assign if_valid     = !fifo_empty;
    assign if_instr     = head.instr;
    assign if_pc        = head.pc;
    assign misalign_err = misalign_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(push);
        stall_count_d = stall_count_q + 32'((state_q == RUN) && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phases from the fetch test plan followed by random
// ready/redirect traffic, checked every cycle against a queue-based model.
// A second instance with RESET_PC = FFFF_FFF8 and ready tied high checks
// PC wrap-around.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instruction_code, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready, misalign_err;
    logic [31:0] pc_w, instruction_code_w, if_instr_w, if_pc_w;
    logic        if_valid_w, misalign_err_w;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, fetch_count_w, stall_count_w;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0094_0333;
        if (a == 32'h4) return 32'h8001_0033;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign instruction_code   = imem(pc);
    assign instruction_code_w = imem(pc_w);

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction_code(instruction_code),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .misalign_err(misalign_err)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(reset), .pc(pc_w), .instruction_code(instruction_code_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(if_valid_w), .if_ready(1'b1), .if_instr(if_instr_w),
        .if_pc(if_pc_w), .misalign_err(misalign_err_w)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count_w), .stall_count(stall_count_w)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: PC, queue of pending entries, first-cycle flag.
    logic [31:0]  m_pc;
    fetch_entry_t m_q[$];
    bit           m_wait;
    bit           m_mis;
    int unsigned  m_fc, m_sc;
    int           since_rst;

    task automatic model_reset();
        m_pc = 32'h0;
        m_q.delete();
        m_wait = 1;
        m_mis = 0;
        m_fc = 0;
        m_sc = 0;
        since_rst = 0;
    endtask

    task automatic compare();
        chk("pc", pc, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("if_pc", if_pc, m_q[0].pc);
            chk("if_instr", if_instr, m_q[0].instr);
        end
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", stall_count, m_sc);
`endif
        if (since_rst <= 6) begin
            chk("wrap_valid", 32'(if_valid_w), 32'(since_rst >= 2));
            if (since_rst >= 2)
                chk("wrap_if_pc", if_pc_w, 32'hFFFF_FFF8 + 32'(4 * (since_rst - 2)));
        end
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic step();
        bit pop, full;
        @(posedge clk);
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && if_ready;
        if (!m_wait && full && !pop) m_sc++;
        m_mis = 0;
        if (redirect_valid) begin
            m_q.delete();
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_mis = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!m_wait && m_q.size() < DEPTH) begin
                m_q.push_back('{pc: m_pc, instr: imem(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fc++;
            end
        end
        m_wait = 0;
        since_rst++;
        #1;
        compare();
        @(negedge clk);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(if_valid), 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
        chk({tag, "_mis"}, 32'(misalign_err), 32'h0);
        chk({tag, "_pc_w"}, pc_w, 32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
        chk({tag, "_fcnt"}, fetch_count, 32'h0);
        chk({tag, "_scnt"}, stall_count, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset          = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Initial reset and release; ready high shows first-fetch latency.
        async_reset("rst0");
        repeat (3) step();
        chk("first_head_pc", if_pc, 32'h4);

        // Fill to two entries, then reset mid-stream.
        if_ready = 1'b0;
        repeat (2) step();
        chk("prerst_full_valid", 32'(if_valid), 32'h1);
        async_reset("rst_mid");

        // Backpressure from release: two entries queued, pc parks at 8.
        repeat (5) step();
        chk("bp_pc", pc, 32'h8);
        if_ready = 1'b1;
        repeat (3) step();

        // Redirect while full with ready high.
        if_ready = 1'b0;
        repeat (3) step();
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        chk("redir_valid_drop", 32'(if_valid), 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("redir_head", if_pc, 32'h100);
        step();

        // Misaligned redirect: aligned target, single-cycle error pulse.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", 32'(misalign_err), 32'h1);
        redirect_valid = 1'b0;
        step();
        chk("mis_clear", 32'(misalign_err), 32'h0);

        // Redirect during WAIT.
        async_reset("rst_wait");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();

        // Random traffic, including redirects near the top of the address space.
        for (int i = 0; i < 400; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : $urandom;
            step();
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage that sits directly upstream of `instruction_memory`. It owns the program counter, drives the `pc` address into the combinational instruction memory, captures the returned `instruction_code`, and delivers {pc, instruction} pairs to the decode stage through a small FIFO with a valid/ready handshake. Redirects from execute (branch or jump) flush the FIFO and reload the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, default 2: FIFO entries. Legal values are 2 or 4.
- `clk`  in  1: sole clock. All state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to `clk`.
- `pc`  out  32: fetch address to `instruction_memory`. Registered.
- `instruction_code`  in  32: instruction word read combinationally at `pc`.
- `redirect_valid`  in  1: redirect request from execute.
- `redirect_pc`  in  32: redirect target.
- `if_valid`  out  1: FIFO head holds a valid entry.
- `if_ready`  in  1: decode accepts the head entry.
- `if_instr`  out  32: instruction at the FIFO head.
- `if_pc`  out  32: PC at the FIFO head.
- `misalign_err`  out  1: one-cycle pulse when `redirect_pc[1:0]` != 0.

## Operation
- FSM states:
  - WAIT: the first cycle after reset release. No fetch occurs, which gives memory one cycle to load. The FSM moves to RUN unconditionally.
  - RUN: normal fetching.
- Pop: occurs when `if_valid && if_ready`.
- Push: occurs in RUN when there is no redirect and the FIFO is not full, or when it is full and a pop happens in the same cycle. A push writes {`pc`, `instruction_code`} to the tail and sets `pc` <= `pc` + 4 (mod 2^32).
- Simultaneous push and pop: count is unchanged. This is legal at both full and empty.
- Redirect has top priority:
  - The FIFO is flushed (count <= 0) and no push occurs.
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - A pop in the same cycle is still counted as accepted by decode, but the flushed entries are discarded.
- Redirect in WAIT: `pc` is loaded and the FSM still moves to RUN.
- `misalign_err` is set for exactly one cycle following a misaligned redirect. The aligned target is still used.
- `if_instr` and `if_pc` hold their values while `if_valid` && !`if_ready`, and are stable until popped.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No error is flagged.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, FSM = WAIT, count = 0.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `misalign_err` = 0.
- Latency:
  - First `if_valid` appears 2 cycles after reset release (WAIT, then push).
  - An instruction pushed at edge N is visible at the head after edge N, provided the FIFO was empty.
- Redirect latency: redirect sampled at edge N gives `pc` = target after N, and `if_valid` = 0 after N. The target instruction is valid after N+1.
- Throughput: one instruction per cycle with `if_ready` held high.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. The FIFO contents are discarded.

## Configuration
- `FETCH_STATS_EN`:
  - Defined: adds `fetch_count` out 32 (pushes) and `stall_count` out 32 (cycles in RUN with the FIFO full and no pop). Both are cleared by reset, wrap at 2^32, and are not cleared by redirect.
  - Undefined: the ports and counters do not exist, and all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum `fetch_state_t` {WAIT, RUN}.
  - Constant `INSTR_BYTES` = 4.
  - Struct `fetch_entry_t` {pc[31:0], instr[31:0]}.
- One sub-module, `fetch_fifo`: parameterised DEPTH, push/pop/flush, with full/empty and count outputs. It is instantiated once.
- PC register, FSM and redirect logic live in `fetch_unit`.

## Test plan
- Reset release with `RESET_PC` = 0, `if_ready` = 1, memory preloaded {0x00940333, 0x80010033}:
  - `if_valid` rises after 2 cycles.
  - `if_pc` = 0 with `if_instr` = 0x00940333, then `if_pc` = 4 with `if_instr` = 0x80010033.
- Backpressure, `if_ready` = 0 for 5 cycles:
  - FIFO fills to 2 and `pc` stops at 8.
  - Releasing backpressure drains pcs 0, 4, 8 in order with no loss or duplication.
- Redirect to 0x100 while full with `if_ready` = 1:
  - The next valid entry has `if_pc` = 0x100.
  - Old entries never appear.
- Redirect to 0x102: `pc` = 0x100, and `misalign_err` pulses for exactly 1 cycle.
- `RESET_PC` = 0xFFFF_FFF8, free-running: `if_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with the FIFO holding 2 entries:
  - `if_valid` = 0 immediately, without waiting for a clock edge.
  - With `FETCH_STATS_EN` defined, the counters read 0.
